// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcode, funct, ALU and state encodings for the control sequencer
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_HALT = 3'd2,
        ST_STEP = 3'd3,
        ST_TRAP = 3'd4
    } state_e;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic [2:0] alu_control;
    } ctrl_t;

endpackage

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - combinational instruction word to raw control bundle plus illegal flag
module main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        // The all-zero word is a NOP, not an R-type with an unknown funct.
        if (instr_i != 32'h0) begin
            case (opcode)
                OP_RTYPE: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.reg_dst   = 1'b1;
                    case (funct)
                        FN_ADD:  ctrl_o.alu_control = ALU_ADD;
                        FN_SUB:  ctrl_o.alu_control = ALU_SUB;
                        FN_AND:  ctrl_o.alu_control = ALU_AND;
                        FN_OR:   ctrl_o.alu_control = ALU_OR;
                        FN_SLT:  ctrl_o.alu_control = ALU_SLT;
                        default: illegal_o = 1'b1;
                    endcase
                end
                OP_LW: begin
                    ctrl_o.reg_write   = 1'b1;
                    ctrl_o.alu_src     = 1'b1;
                    ctrl_o.mem_to_reg  = 1'b1;
                    ctrl_o.alu_control = ALU_ADD;
                end
                OP_SW: begin
                    ctrl_o.mem_write   = 1'b1;
                    ctrl_o.alu_src     = 1'b1;
                    ctrl_o.alu_control = ALU_ADD;
                end
                OP_BEQ: begin
                    ctrl_o.branch      = 1'b1;
                    ctrl_o.alu_control = ALU_SUB;
                end
                OP_ADDI: begin
                    ctrl_o.reg_write   = 1'b1;
                    ctrl_o.alu_src     = 1'b1;
                    ctrl_o.alu_control = ALU_ADD;
                end
                default: illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mips_control_sequencer.sv
// rtl/mips_control_sequencer.sv - run/halt/step sequencer gating decoded controls, retire counter and trap capture
module mips_control_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic                 step,
    input  logic [31:0]          Instr,
    input  logic [31:0]          pc,
    output logic                 RegWrite,
    output logic                 RegDst,
    output logic                 ALUSrc,
    output logic                 Branch,
    output logic                 MemWrite,
    output logic                 MemtoReg,
    output logic [2:0]           ALUControl,
    output logic                 pc_en,
    output logic [2:0]           state_o,
    output logic [CNT_WIDTH-1:0] retired,
    output logic                 trap,
    output logic [31:0]          trap_pc,
    output logic [31:0]          trap_instr
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] retired_q;
    logic                 trap_q;
    logic [31:0]          trap_pc_q;
    logic [31:0]          trap_instr_q;

    ctrl_t ctrl_raw;
    ctrl_t ctrl_gated;
    logic  illegal;
    logic  executing;
    logic  fire;
    logic  enter_trap;

    main_decoder u_main_decoder (
        .instr_i   (Instr),
        .ctrl_o    (ctrl_raw),
        .illegal_o (illegal)
    );

    assign executing  = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign fire       = executing && !illegal;
    assign enter_trap = executing && illegal;
    assign ctrl_gated = fire ? ctrl_raw : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (illegal)       state_d = ST_TRAP;
                else if (halt_req) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (start)     state_d = ST_RUN;
                else if (step) state_d = ST_STEP;
            end
            // Always returning to HALT is what makes a held step re-arm every other cycle.
            ST_STEP: state_d = illegal ? ST_TRAP : ST_HALT;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            retired_q    <= '0;
            trap_q       <= 1'b0;
            trap_pc_q    <= '0;
            trap_instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (fire) retired_q <= retired_q + CNT_WIDTH'(1);
            if (enter_trap) begin
                trap_q       <= 1'b1;
                trap_pc_q    <= pc;
                trap_instr_q <= Instr;
            end
        end
    end

    assign RegWrite   = ctrl_gated.reg_write;
    assign RegDst     = ctrl_gated.reg_dst;
    assign ALUSrc     = ctrl_gated.alu_src;
    assign Branch     = ctrl_gated.branch;
    assign MemWrite   = ctrl_gated.mem_write;
    assign MemtoReg   = ctrl_gated.mem_to_reg;
    assign ALUControl = ctrl_gated.alu_control;
    assign pc_en      = fire;
    assign state_o    = state_q;
    assign retired    = retired_q;
    assign trap       = trap_q;
    assign trap_pc    = trap_pc_q;
    assign trap_instr = trap_instr_q;

endmodule

// File: tb/tb_mips_control_sequencer.sv
// tb/tb_mips_control_sequencer.sv - directed and randomized bench against a behavioural sequencer model
module tb_mips_control_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        step = 1'b0;
    logic [31:0] Instr = 32'h0;
    logic [31:0] pc = 32'h0;

    logic        RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg;
    logic [2:0]  ALUControl;
    logic        pc_en;
    logic [2:0]  state_o;
    logic [31:0] retired;
    logic        trap;
    logic [31:0] trap_pc, trap_instr;

    logic        d4_RegWrite, d4_RegDst, d4_ALUSrc, d4_Branch, d4_MemWrite, d4_MemtoReg;
    logic [2:0]  d4_ALUControl;
    logic        d4_pc_en;
    logic [2:0]  d4_state_o;
    logic [3:0]  d4_retired;
    logic        d4_trap;
    logic [31:0] d4_trap_pc, d4_trap_instr;

    int checks = 0;
    int failures = 0;

    int          m_state = 0;
    logic [31:0] m_ret = 0;
    logic        m_trap = 0;
    logic [31:0] m_tpc = 0;
    logic [31:0] m_tinstr = 0;

    always #5 clk = ~clk;

    mips_control_sequencer #(.CNT_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .step(step),
        .Instr(Instr), .pc(pc),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .Branch(Branch),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUControl(ALUControl),
        .pc_en(pc_en), .state_o(state_o), .retired(retired),
        .trap(trap), .trap_pc(trap_pc), .trap_instr(trap_instr)
    );

    mips_control_sequencer #(.CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .step(step),
        .Instr(Instr), .pc(pc),
        .RegWrite(d4_RegWrite), .RegDst(d4_RegDst), .ALUSrc(d4_ALUSrc), .Branch(d4_Branch),
        .MemWrite(d4_MemWrite), .MemtoReg(d4_MemtoReg), .ALUControl(d4_ALUControl),
        .pc_en(d4_pc_en), .state_o(d4_state_o), .retired(d4_retired),
        .trap(d4_trap), .trap_pc(d4_trap_pc), .trap_instr(d4_trap_instr)
    );

    // {legal, RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, ALUControl}
    function automatic logic [9:0] ref_decode(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (ins == 32'h0) return 10'b10_0000_0000;
        if (op == 6'h00) begin
            if (fn == 6'h20) return {7'b1110000, 3'd2};
            if (fn == 6'h22) return {7'b1110000, 3'd6};
            if (fn == 6'h24) return {7'b1110000, 3'd0};
            if (fn == 6'h25) return {7'b1110000, 3'd1};
            if (fn == 6'h2A) return {7'b1110000, 3'd7};
            return 10'd0;
        end
        if (op == 6'h23) return {7'b1101001, 3'd2};
        if (op == 6'h2B) return {7'b1001010, 3'd2};
        if (op == 6'h04) return {7'b1000100, 3'd6};
        if (op == 6'h08) return {7'b1101000, 3'd2};
        return 10'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic [31:0] ins);
        logic [9:0] d;
        logic       fire;
        d    = ref_decode(ins);
        fire = (m_state == 1 || m_state == 3) && d[9];
        chk("state", {29'd0, state_o}, m_state);
        chk("ctrl", {23'd0, RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, ALUControl},
            fire ? {23'd0, d[8:0]} : 32'd0);
        chk("pc_en", {31'd0, pc_en}, {31'd0, fire});
        chk("retired", retired, m_ret);
        chk("retired4", {28'd0, d4_retired}, m_ret & 32'hF);
        chk("trap", {31'd0, trap}, {31'd0, m_trap});
        chk("trap_pc", trap_pc, m_tpc);
        chk("trap_instr", trap_instr, m_tinstr);
    endtask

    task automatic cyc(input logic s, input logic h, input logic st,
                       input logic [31:0] ins, input logic [31:0] p);
        logic [9:0] d;
        logic       exec;
        start = s; halt_req = h; step = st; Instr = ins; pc = p;
        #1;
        check_outputs(ins);
        d    = ref_decode(ins);
        exec = (m_state == 1 || m_state == 3);
        @(posedge clk);
        if (exec && d[9]) m_ret = m_ret + 1;
        if (exec && !d[9]) begin
            m_trap = 1; m_tpc = p; m_tinstr = ins;
        end
        case (m_state)
            0: if (s) m_state = 1;
            1: if (!d[9]) m_state = 4; else if (h) m_state = 2;
            2: if (s) m_state = 1; else if (st) m_state = 3;
            3: m_state = d[9] ? 2 : 4;
            default: m_state = 4;
        endcase
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] ins);
        start = 1'b1; Instr = ins;
        reset = 1'b0;
        m_state = 0; m_ret = 0; m_trap = 0; m_tpc = 0; m_tinstr = 0;
        #1;
        check_outputs(ins);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  fns [5];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        r = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2: return {6'h00, r[25:6], fns[$urandom_range(0, 4)]};
            3:       return {6'h23, r[25:0]};
            4:       return {6'h2B, r[25:0]};
            5:       return {6'h04, r[25:0]};
            6:       return {6'h08, r[25:0]};
            7:       return 32'h0;
            default: return r;
        endcase
    endfunction

    initial begin
        @(negedge clk);
        do_reset(32'h20080005);

        // Start, then addi/add/sw/lw stream.
        cyc(1, 0, 0, 32'h20080005, 32'h0);
        cyc(0, 0, 0, 32'h20080005, 32'h0);
        cyc(0, 0, 0, 32'h01084820, 32'h4);
        cyc(0, 0, 0, 32'hAC090000, 32'h8);
        cyc(0, 0, 0, 32'h8C0A0000, 32'hC);
        // halt_req with add: add still executes, then frozen in HALT.
        cyc(0, 1, 0, 32'h01084820, 32'h10);
        cyc(0, 0, 0, 32'h01084820, 32'h14);
        cyc(0, 0, 0, 32'h01084820, 32'h14);
        // Held step with beq: one execution every two cycles.
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 32'h11090002, 32'h14);
        cyc(0, 0, 0, 32'h11090002, 32'h14);
        // Resume and hit j: trap, then start/step are ignored.
        cyc(1, 0, 0, 32'h0, 32'h18);
        cyc(0, 0, 0, 32'h0, 32'h18);
        cyc(0, 1, 0, 32'h08000010, 32'h1C);
        cyc(1, 0, 1, 32'h0, 32'h20);
        cyc(1, 0, 0, 32'h0, 32'h24);

        // Illegal funct traps; NOP retires.
        do_reset(32'h0);
        cyc(1, 0, 0, 32'h0, 32'h0);
        cyc(0, 0, 0, 32'h0, 32'h0);
        cyc(0, 0, 0, 32'h01084807, 32'h40);
        cyc(0, 0, 0, 32'h0, 32'h44);

        // Reset mid-RUN with retired=7, then wrap the 4-bit counter.
        do_reset(32'h0);
        cyc(1, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 32'h0, 32'h0);
        chk("retired_before_reset", retired, 32'd7);
        do_reset(32'h01084820);
        cyc(1, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 32'h20080005, 32'h0);
        chk("retired4_wrap", {28'd0, d4_retired}, 32'd0);
        cyc(0, 0, 0, 32'h0, 32'h0);

        // Randomized phase.
        do_reset(32'h0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset(rand_instr());
            end else begin
                cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 2) == 0), rand_instr(), $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
